// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue between instruction memory and the ID stage of pipe_MIPS32.
// Define FETCHQ_BYPASS_EN to forward a response straight to ID when the queue is empty.
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk1,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_npc,
    input  logic        id_ready,
    output logic        fetch_idle
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] fifo_ir_q  [DEPTH];
    logic [31:0] fifo_ir_d  [DEPTH];
    logic [31:0] fifo_npc_q [DEPTH];
    logic [31:0] fifo_npc_d [DEPTH];
    logic [31:0] sh_npc_q   [DEPTH];
    logic [31:0] sh_npc_d   [DEPTH];
    ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    ptr_t        sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
    cnt_t        count_q, count_d, outstanding_q, outstanding_d, drop_q, drop_d;
    logic        stopped_q, stopped_d;

    logic        accept, drop_hit, bypass, push, pop, fifo_empty, hlt_seen;
    logic [CW:0] credit_used;

    assign imem_addr = pc_q;

    always_comb begin
        fifo_empty  = (count_q == '0);
        // Credits cover both queued and in-flight words, so a response always has a slot.
        credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req    = !rst && !stopped_q && !redirect && (credit_used < DEPTH_W);
        accept      = imem_req && imem_ready;
        drop_hit    = imem_rvalid && (drop_q != '0);
`ifdef FETCHQ_BYPASS_EN
        bypass      = fifo_empty && (drop_q == '0) && imem_rvalid && id_ready && !redirect;
`else
        bypass      = 1'b0;
`endif
        push        = imem_rvalid && !drop_hit && !redirect && !bypass;
        pop         = !fifo_empty && id_ready && !redirect;
        hlt_seen    = (push || bypass) && (imem_rdata[31:26] == 6'b111111);
        id_valid    = (!fifo_empty || bypass) && !redirect;
        id_ir       = '0;
        id_npc      = '0;
        if (!fifo_empty) begin
            id_ir  = fifo_ir_q[rd_ptr_q];
            id_npc = fifo_npc_q[rd_ptr_q];
        end else if (bypass) begin
            id_ir  = imem_rdata;
            id_npc = sh_npc_q[sh_rd_q];
        end
        fetch_idle  = stopped_q && fifo_empty && (outstanding_q == '0);
    end

    always_comb begin
        pc_d          = pc_q;
        fifo_ir_d     = fifo_ir_q;
        fifo_npc_d    = fifo_npc_q;
        sh_npc_d      = sh_npc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        sh_rd_d       = sh_rd_q;
        sh_wr_d       = sh_wr_q;
        drop_d        = drop_q;
        stopped_d     = stopped_q;
        outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(imem_rvalid);
        count_d       = count_q + cnt_t'(push) - cnt_t'(pop);

        if (accept) begin
            sh_npc_d[sh_wr_q] = pc_q + 32'd1;
            sh_wr_d           = sh_wr_q + ptr_t'(1);
            pc_d              = pc_q + 32'd1;
        end
        if (imem_rvalid) begin
            sh_rd_d = sh_rd_q + ptr_t'(1);
        end
        if (drop_hit) begin
            drop_d = drop_q - cnt_t'(1);
        end
        if (push) begin
            fifo_ir_d[wr_ptr_q]  = imem_rdata;
            fifo_npc_d[wr_ptr_q] = sh_npc_q[sh_rd_q];
            wr_ptr_d             = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        if (hlt_seen) begin
            stopped_d = 1'b1;
        end
        // Every word still in flight belongs to the wrong path, including one arriving now.
        if (redirect) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            drop_d    = outstanding_q - cnt_t'(imem_rvalid);
            pc_d      = redirect_pc;
            stopped_d = 1'b0;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            sh_rd_q       <= '0;
            sh_wr_q       <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            stopped_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ir_q[i]  <= '0;
                fifo_npc_q[i] <= '0;
                sh_npc_q[i]   <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            sh_rd_q       <= sh_rd_d;
            sh_wr_q       <= sh_wr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            stopped_q     <= stopped_d;
            fifo_ir_q     <= fifo_ir_d;
            fifo_npc_q    <= fifo_npc_d;
            sh_npc_q      <= sh_npc_d;
        end
    end
endmodule

// File: tb/tb_mips_fetch_queue.sv
// Self-checking bench for mips_fetch_queue: randomized in-order memory, sequential-stream scoreboard.
module tb_mips_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NO_HLT   = 32'hFFFF_FFF0;

    logic        clk1, rst;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready, fetch_idle;
    logic [31:0] id_ir, id_npc;

    mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk1(clk1), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ir(id_ir), .id_npc(id_npc), .id_ready(id_ready),
        .fetch_idle(fetch_idle)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];

    int          checks, failures, cyc;
    int          rdy_pct, idr_pct, lat_min, lat_max;
    int          dlv_cnt, acc_cnt;
    logic [31:0] hlt_addr, exp_next, req_next, last_ir, last_npc, max_acc;
    logic        s_req, s_valid, s_idle;
    logic [31:0] s_addr, s_ir, s_npc;

    // Instruction memory contents: a hash of the address, with HLT only at hlt_addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a * 32'h9E37_79B1 + 32'h0123_4567;
        if (a == hlt_addr) w[31:26] = 6'b111111;
        else if (w[31:26] == 6'b111111) w[31] = 1'b0;
        return w;
    endfunction

    // One clock cycle: drive at negedge, observe settled outputs, update memory and stream model.
    task automatic step(input logic redir, input logic [31:0] rpc);
        mreq_t r;
        @(negedge clk1);
        imem_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        id_ready    = (int'($urandom_range(0, 99)) < idr_pct);
        redirect    = redir;
        redirect_pc = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
        s_ir = id_ir; s_npc = id_npc; s_idle = fetch_idle;
        if (redir) begin
            checks++;
            if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
                failures++;
                $display("FAIL redirect_quiet: imem_req=%b id_valid=%b, required 0 0", imem_req, id_valid);
            end
        end
        if (id_valid && id_ready) begin
            checks++;
            if (id_ir !== mem_word(exp_next) || id_npc !== exp_next + 32'd1) begin
                failures++;
                $display("FAIL deliver: got ir=%h npc=%h, required ir=%h npc=%h",
                         id_ir, id_npc, mem_word(exp_next), exp_next + 32'd1);
                exp_next = id_npc - 32'd1;
            end
            last_ir = id_ir; last_npc = id_npc;
            exp_next = exp_next + 32'd1;
            dlv_cnt++;
        end
        if (imem_req && imem_ready) begin
            checks++;
            if (imem_addr !== req_next) begin
                failures++;
                $display("FAIL fetch_addr: got %h, required %h", imem_addr, req_next);
            end
            r.addr = imem_addr;
            r.due  = cyc + int'($urandom_range(lat_min, lat_max));
            mq.push_back(r);
            max_acc  = imem_addr;
            req_next = imem_addr + 32'd1;
            acc_cnt++;
        end
        if (imem_rvalid) void'(mq.pop_front());
        if (redir) begin
            exp_next = rpc;
            req_next = rpc;
        end
        cyc++;
    endtask

    task automatic reset_assert();
        @(negedge clk1);
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
        #1;
        mq.delete();
        exp_next = RESET_PC; req_next = RESET_PC; hlt_addr = NO_HLT;
    endtask

    task automatic reset_release();
        @(posedge clk1);
        #2 rst = 1'b0;
    endtask

    task automatic set_mem(input int rp, input int ip, input int lmin, input int lmax);
        rdy_pct = rp; idr_pct = ip; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic test_reset();
        reset_assert();
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", id_valid); end
        checks++;
        if (id_ir !== 32'h0 || id_npc !== 32'h0) begin
            failures++; $display("FAIL reset_head: got ir=%h npc=%h, required 0 0", id_ir, id_npc);
        end
        checks++;
        if (fetch_idle !== 1'b0) begin failures++; $display("FAIL reset_idle: got %b, required 0", fetch_idle); end
        repeat (2) @(negedge clk1);
        reset_release();
        set_mem(100, 100, 1, 1);
        step(1'b0, '0);
        checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
            failures++; $display("FAIL first_req: got req=%b addr=%h, required 1 %h", s_req, s_addr, RESET_PC);
        end
    endtask

    task automatic test_load_to_use();
        reset_assert(); reset_release();
        set_mem(100, 100, 1, 1);
        step(1'b0, '0);
        step(1'b0, '0);
`ifdef FETCHQ_BYPASS_EN
        checks++;
        if (s_valid !== 1'b1 || s_npc !== RESET_PC + 32'd1) begin
            failures++; $display("FAIL bypass_same_cycle: got valid=%b npc=%h, required 1 %h", s_valid, s_npc, RESET_PC + 32'd1);
        end
`else
        checks++;
        if (s_valid !== 1'b0) begin failures++; $display("FAIL load_to_use_early: got valid=%b, required 0", s_valid); end
        step(1'b0, '0);
        checks++;
        if (s_valid !== 1'b1 || s_npc !== RESET_PC + 32'd1) begin
            failures++; $display("FAIL load_to_use: got valid=%b npc=%h, required 1 %h", s_valid, s_npc, RESET_PC + 32'd1);
        end
`endif
    endtask

    task automatic test_stream();
        int d0, a0;
        reset_assert(); reset_release();
        set_mem(100, 100, 1, 1);
        repeat (10) step(1'b0, '0);
        d0 = dlv_cnt; a0 = acc_cnt;
        repeat (30) step(1'b0, '0);
        checks++;
        if (dlv_cnt - d0 != 30) begin failures++; $display("FAIL stream_rate: got %0d deliveries in 30 cycles, required 30", dlv_cnt - d0); end
        checks++;
        if (acc_cnt - a0 != 30) begin failures++; $display("FAIL fetch_rate: got %0d requests in 30 cycles, required 30", acc_cnt - a0); end
    endtask

    task automatic test_backpressure();
        int a0, d0;
        reset_assert(); reset_release();
        set_mem(100, 0, 2, 2);
        a0 = acc_cnt; d0 = dlv_cnt;
        repeat (12) step(1'b0, '0);
        checks++;
        if (acc_cnt - a0 != DEPTH) begin failures++; $display("FAIL credit_limit: got %0d accepted, required %0d", acc_cnt - a0, DEPTH); end
        checks++;
        if (s_req !== 1'b0) begin failures++; $display("FAIL full_req: got %b, required 0", s_req); end
        checks++;
        if (dlv_cnt != d0) begin failures++; $display("FAIL stall_deliver: got %0d, required 0", dlv_cnt - d0); end
        idr_pct = 100;
        repeat (20) step(1'b0, '0);
        checks++;
        if (dlv_cnt - d0 < 10) begin failures++; $display("FAIL drain: got %0d deliveries, required at least 10", dlv_cnt - d0); end
    endtask

    task automatic test_redirect();
        int d0, n;
        reset_assert(); reset_release();
        set_mem(100, 0, 3, 3);
        repeat (5) step(1'b0, '0);
        step(1'b1, 32'h40);
        idr_pct = 100;
        d0 = dlv_cnt; n = 0;
        while (dlv_cnt == d0 && n < 30) begin step(1'b0, '0); n++; end
        checks++;
        if (dlv_cnt == d0) begin
            failures++; $display("FAIL redirect_resume: no delivery within 30 cycles, required 1");
        end else begin
            checks++;
            if (last_ir !== mem_word(32'h40) || last_npc !== 32'h41) begin
                failures++; $display("FAIL redirect_target: got ir=%h npc=%h, required %h 00000041", last_ir, last_npc, mem_word(32'h40));
            end
        end
    endtask

    task automatic test_hlt();
        int n, a0, d0;
        reset_assert(); reset_release();
        hlt_addr = RESET_PC + 32'd5;
        set_mem(100, 100, 2, 2);
        n = 0;
        step(1'b0, '0);
        while (!s_idle && n < 60) begin step(1'b0, '0); n++; end
        checks++;
        if (!s_idle) begin failures++; $display("FAIL hlt_idle: fetch_idle=0 after 60 cycles, required 1"); end
        checks++;
        if (max_acc < hlt_addr || max_acc > hlt_addr + DEPTH) begin
            failures++; $display("FAIL hlt_stop: last fetch %h, required %h..%h", max_acc, hlt_addr, hlt_addr + DEPTH);
        end
        checks++;
        if (last_npc !== max_acc + 32'd1) begin
            failures++; $display("FAIL hlt_inflight: last npc %h, required %h", last_npc, max_acc + 32'd1);
        end
        a0 = acc_cnt;
        repeat (8) step(1'b0, '0);
        checks++;
        if (acc_cnt != a0 || s_req !== 1'b0 || s_idle !== 1'b1) begin
            failures++; $display("FAIL hlt_hold: new reqs=%0d req=%b idle=%b, required 0 0 1", acc_cnt - a0, s_req, s_idle);
        end
        step(1'b1, 32'h0);
        d0 = dlv_cnt; n = 0;
        while (dlv_cnt == d0 && n < 30) begin step(1'b0, '0); n++; end
        checks++;
        if (dlv_cnt == d0 || last_npc !== 32'h1 || last_ir !== mem_word(32'h0) || s_idle !== 1'b0) begin
            failures++; $display("FAIL hlt_resume: got npc=%h ir=%h idle=%b, required 00000001 %h 0", last_npc, last_ir, s_idle, mem_word(32'h0));
        end
    endtask

    task automatic test_wrap();
        int d0, n;
        reset_assert(); reset_release();
        set_mem(100, 100, 1, 2);
        repeat (3) step(1'b0, '0);
        step(1'b1, 32'hFFFF_FFFD);
        d0 = dlv_cnt; n = 0;
        while (dlv_cnt < d0 + 5 && n < 40) begin step(1'b0, '0); n++; end
        checks++;
        if (dlv_cnt < d0 + 5 || last_npc !== 32'h2) begin
            failures++; $display("FAIL pc_wrap: got %0d deliveries last npc=%h, required 5 00000002", dlv_cnt - d0, last_npc);
        end
    endtask

    task automatic test_midreset();
        int d0;
        reset_assert(); reset_release();
        set_mem(100, 0, 1, 1);
        repeat (4) step(1'b0, '0);
        checks++;
        if (s_valid !== 1'b1) begin failures++; $display("FAIL prefill: got valid=%b, required 1", s_valid); end
        reset_assert();
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0 || id_ir !== 32'h0) begin
            failures++; $display("FAIL midreset_clear: got valid=%b req=%b ir=%h, required 0 0 0", id_valid, imem_req, id_ir);
        end
        reset_release();
        set_mem(100, 100, 1, 1);
        d0 = dlv_cnt;
        step(1'b0, '0);
        checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
            failures++; $display("FAIL midreset_first: got req=%b addr=%h, required 1 %h", s_req, s_addr, RESET_PC);
        end
        repeat (10) step(1'b0, '0);
        checks++;
        if (dlv_cnt - d0 < 5) begin failures++; $display("FAIL midreset_flow: got %0d deliveries, required at least 5", dlv_cnt - d0); end
    endtask

    task automatic test_random();
        int d0;
        logic redir;
        logic [31:0] rpc;
        reset_assert(); reset_release();
        set_mem(60, 60, 1, 4);
        d0 = dlv_cnt;
        for (int i = 0; i < 600; i++) begin
            redir = (int'($urandom_range(0, 99)) < 4);
            rpc   = $urandom & 32'h0000_FFFF;
            step(redir, rpc);
        end
        checks++;
        if (dlv_cnt - d0 < 60) begin failures++; $display("FAIL random_progress: got %0d deliveries, required at least 60", dlv_cnt - d0); end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; dlv_cnt = 0; acc_cnt = 0;
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        hlt_addr = NO_HLT; exp_next = RESET_PC; req_next = RESET_PC;
        last_ir = '0; last_npc = '0; max_acc = '0;
        set_mem(100, 100, 1, 1);
        test_reset();
        test_load_to_use();
        test_stream();
        test_backpressure();
        test_redirect();
        test_hlt();
        test_wrap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
